// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//
// Control path of a five-stage RISC-V style pipeline. Carries decode-stage
// control fields and register indices through the E, M and W pipeline
// registers, and provides the hazard unit:
//   - load-use detection with F/D stall and E bubble
//   - branch/jump resolution in E with D/E flush
//   - M/W to E operand forwarding selects
//   - saturating stall and flush performance counters
//
// Parameters
//   CNT_W        width of stall_cnt / flush_cnt
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   *D inputs    decode-stage controls and register indices
//   ZeroE, LtE   ALU flags for the instruction currently in E
//   *E outputs   E-stage pipeline register contents
//   *M outputs   M-stage pipeline register contents
//   *W outputs   W-stage pipeline register contents
//   StallF/D     hold fetch and decode (load-use hazard)
//   FlushD/E     squash decode / insert bubble into E
//   PCSrcE       redirect PC to the branch/jump target
//   ForwardAE/BE operand source select: 00 regfile, 01 W result, 10 M ALU
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of taken branches/jumps
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  // Decode-stage inputs
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             ALUSrcD,
  input  logic             sel_adderD,
  input  logic [1:0]       ResultSrcD,
  input  logic [1:0]       BranchD,
  input  logic [2:0]       ALUControlD,
  input  logic [2:0]       ImmSrcD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,

  // ALU flags for the instruction in E
  input  logic             ZeroE,
  input  logic             LtE,

  // Execute-stage outputs
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [2:0]       ImmSrcE,
  output logic             sel_adderE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,

  // Memory-stage outputs
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RdM,

  // Writeback-stage outputs
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,

  // Hazard unit outputs
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,

  // Performance counters
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Result source encoding used by the load-use check
  localparam logic [1:0] RES_MEM = 2'b01;

  // Branch type encoding
  localparam logic [1:0] BR_BEQ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;
  localparam logic [1:0] BR_BLT = 2'b11;

  // Forwarding select encoding
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic       r_regWriteE;
  logic       r_memWriteE;
  logic       r_jumpE;
  logic       r_aluSrcE;
  logic       r_selAdderE;
  logic [1:0] r_resultSrcE;
  logic [1:0] r_branchE;
  logic [2:0] r_aluControlE;
  logic [2:0] r_immSrcE;
  logic [4:0] r_rs1E;
  logic [4:0] r_rs2E;
  logic [4:0] r_rdE;

  logic       r_regWriteM;
  logic       r_memWriteM;
  logic [1:0] r_resultSrcM;
  logic [4:0] r_rdM;

  logic       r_regWriteW;
  logic [1:0] r_resultSrcW;
  logic [4:0] r_rdW;

  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  // -------------------------------------------------------------------------
  // Hazard and redirect signals
  // -------------------------------------------------------------------------
  logic       w_pcSrcE;
  logic       w_lwStall;
  logic       w_stall;
  logic       w_flushE;
  logic [1:0] w_forwardA;
  logic [1:0] w_forwardB;

  // Forward select for one E source operand. The M stage holds the younger
  // producer, so it wins over W. x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                        input logic       regWriteM,
                                        input logic [4:0] rdM,
                                        input logic       regWriteW,
                                        input logic [4:0] rdW);
    logic [1:0] sel;
    sel = FWD_RF;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs))
      sel = FWD_M;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
      sel = FWD_W;
    return sel;
  endfunction

  // Branch/jump resolution, load-use detection and forwarding. Everything is
  // gated by rst_n so the hazard outputs read zero for the whole reset
  // window, independent of the ALU flags still toggling outside.
  always_comb begin
    w_pcSrcE   = 1'b0;
    w_lwStall  = 1'b0;
    w_forwardA = FWD_RF;
    w_forwardB = FWD_RF;
    if (rst_n) begin
      w_pcSrcE = r_jumpE
               | ((r_branchE == BR_BEQ) &  ZeroE)
               | ((r_branchE == BR_BNE) & ~ZeroE)
               | ((r_branchE == BR_BLT) &  LtE);

      // A load in E whose destination is read by the instruction in D
      // cannot be forwarded in time; the consumer waits one cycle.
      w_lwStall = (r_resultSrcE == RES_MEM) && (r_rdE != 5'd0) &&
                  ((r_rdE == Rs1D) || (r_rdE == Rs2D));

      w_forwardA = fwdSel(r_rs1E, r_regWriteM, r_rdM, r_regWriteW, r_rdW);
      w_forwardB = fwdSel(r_rs2E, r_regWriteM, r_rdM, r_regWriteW, r_rdW);
    end
  end

  // A taken branch/jump squashes the stalled consumer anyway, so the
  // redirect overrides the stall rather than holding a dead instruction.
  assign w_stall  = w_lwStall & ~w_pcSrcE;
  assign w_flushE = w_lwStall | w_pcSrcE;

  // -------------------------------------------------------------------------
  // D -> E register. A flush loads an all-zero bubble, which is a harmless
  // no-op: no register write, no memory write, no branch, no jump.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWriteE   <= 1'b0;
      r_memWriteE   <= 1'b0;
      r_jumpE       <= 1'b0;
      r_aluSrcE     <= 1'b0;
      r_selAdderE   <= 1'b0;
      r_resultSrcE  <= 2'b00;
      r_branchE     <= 2'b00;
      r_aluControlE <= 3'b000;
      r_immSrcE     <= 3'b000;
      r_rs1E        <= 5'd0;
      r_rs2E        <= 5'd0;
      r_rdE         <= 5'd0;
    end else if (w_flushE) begin
      r_regWriteE   <= 1'b0;
      r_memWriteE   <= 1'b0;
      r_jumpE       <= 1'b0;
      r_aluSrcE     <= 1'b0;
      r_selAdderE   <= 1'b0;
      r_resultSrcE  <= 2'b00;
      r_branchE     <= 2'b00;
      r_aluControlE <= 3'b000;
      r_immSrcE     <= 3'b000;
      r_rs1E        <= 5'd0;
      r_rs2E        <= 5'd0;
      r_rdE         <= 5'd0;
    end else begin
      r_regWriteE   <= RegWriteD;
      r_memWriteE   <= MemWriteD;
      r_jumpE       <= JumpD;
      r_aluSrcE     <= ALUSrcD;
      r_selAdderE   <= sel_adderD;
      r_resultSrcE  <= ResultSrcD;
      r_branchE     <= BranchD;
      r_aluControlE <= ALUControlD;
      r_immSrcE     <= ImmSrcD;
      r_rs1E        <= Rs1D;
      r_rs2E        <= Rs2D;
      r_rdE         <= RdD;
    end
  end

  // -------------------------------------------------------------------------
  // E -> M and M -> W registers. These never stall: once an instruction has
  // left D it always drains to writeback.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= 2'b00;
      r_rdM        <= 5'd0;
      r_regWriteW  <= 1'b0;
      r_resultSrcW <= 2'b00;
      r_rdW        <= 5'd0;
    end else begin
      r_regWriteM  <= r_regWriteE;
      r_memWriteM  <= r_memWriteE;
      r_resultSrcM <= r_resultSrcE;
      r_rdM        <= r_rdE;
      r_regWriteW  <= r_regWriteM;
      r_resultSrcW <= r_resultSrcM;
      r_rdW        <= r_rdM;
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters, saturating at all-ones so a long run never wraps
  // back to a misleadingly small value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_pcSrcE && (r_flushCnt != '1))
        r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign RegWriteE   = r_regWriteE;
  assign MemWriteE   = r_memWriteE;
  assign ResultSrcE  = r_resultSrcE;
  assign ALUControlE = r_aluControlE;
  assign ALUSrcE     = r_aluSrcE;
  assign ImmSrcE     = r_immSrcE;
  assign sel_adderE  = r_selAdderE;
  assign Rs1E        = r_rs1E;
  assign Rs2E        = r_rs2E;
  assign RdE         = r_rdE;

  assign RegWriteM   = r_regWriteM;
  assign MemWriteM   = r_memWriteM;
  assign ResultSrcM  = r_resultSrcM;
  assign RdM         = r_rdM;

  assign RegWriteW   = r_regWriteW;
  assign ResultSrcW  = r_resultSrcW;
  assign RdW         = r_rdW;

  assign StallF      = w_stall;
  assign StallD      = w_stall;
  assign FlushD      = w_pcSrcE;
  assign FlushE      = w_flushE;
  assign PCSrcE      = w_pcSrcE;
  assign ForwardAE   = w_forwardA;
  assign ForwardBE   = w_forwardB;

  assign stall_cnt   = r_stallCnt;
  assign flush_cnt   = r_flushCnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
//
// Directed testbench for ctrl_pipe with small counters (CNT_W=2) so that
// saturation is reachable in a few cycles. Inputs change one time unit after
// a rising edge; outputs are checked between edges.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             RegWriteD, MemWriteD, JumpD, ALUSrcD, sel_adderD;
  logic [1:0]       ResultSrcD, BranchD;
  logic [2:0]       ALUControlD, ImmSrcD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             ZeroE, LtE;
  logic             RegWriteE, MemWriteE, ALUSrcE, sel_adderE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE, ImmSrcE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             RegWriteM, MemWriteM;
  logic [1:0]       ResultSrcM;
  logic [4:0]       RdM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic [4:0]       RdW;
  logic             StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int compCount;
  int mismatchCount;

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .ALUSrcD(ALUSrcD), .sel_adderD(sel_adderD), .ResultSrcD(ResultSrcD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .ImmSrcD(ImmSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE), .LtE(LtE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ImmSrcE(ImmSrcE),
    .sel_adderE(sel_adderE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a run that never reaches the summary
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drive the decode-stage inputs and let combinational logic settle
  task automatic applyStimulus(input logic regW, input logic memW,
                               input logic jump, input logic aluSrc,
                               input logic selAdder, input logic [1:0] resSrc,
                               input logic [1:0] branch,
                               input logic [2:0] aluCtl,
                               input logic [2:0] immSrc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
    RegWriteD   = regW;
    MemWriteD   = memW;
    JumpD       = jump;
    ALUSrcD     = aluSrc;
    sel_adderD  = selAdder;
    ResultSrcD  = resSrc;
    BranchD     = branch;
    ALUControlD = aluCtl;
    ImmSrcD     = immSrc;
    Rs1D        = rs1;
    Rs2D        = rs2;
    RdD         = rd;
    #1;
  endtask

  // Advance one clock and step just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between edges, leaving a nop on the D inputs
  task automatic doReset();
    rst_n = 1'b0;
    ZeroE = 1'b0;
    LtE   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    compCount     = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    ZeroE = 1'b0;
    LtE   = 1'b0;

    // Reset holds the pipeline empty even across an edge with live D inputs
    applyStimulus(1, 1, 1, 1, 1, 2'b01, 2'b10, 3'b111, 3'b101, 5, 5, 5);
    tick();
    checkOutput("rst_RegWriteE", RegWriteE, 0);
    checkOutput("rst_RdE", RdE, 0);
    checkOutput("rst_ALUControlE", ALUControlE, 0);
    checkOutput("rst_RegWriteM", RegWriteM, 0);
    checkOutput("rst_RdW", RdW, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_flush_cnt", flush_cnt, 0);
    checkOutput("rst_StallF", StallF, 0);
    checkOutput("rst_FlushE", FlushE, 0);
    checkOutput("rst_PCSrcE", PCSrcE, 0);
    doReset();

    // Load-use: lw x5 then add using x5
    applyStimulus(1, 0, 0, 1, 1, 2'b01, 2'b00, 3'b010, 3'b011, 1, 0, 5);
    tick();
    checkOutput("lu_RegWriteE", RegWriteE, 1);
    checkOutput("lu_ResultSrcE", ResultSrcE, 1);
    checkOutput("lu_RdE", RdE, 5);
    checkOutput("lu_ALUControlE", ALUControlE, 3'b010);
    checkOutput("lu_ImmSrcE", ImmSrcE, 3'b011);
    checkOutput("lu_sel_adderE", sel_adderE, 1);
    checkOutput("lu_ALUSrcE", ALUSrcE, 1);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 5, 6, 7);
    checkOutput("lu_StallF", StallF, 1);
    checkOutput("lu_StallD", StallD, 1);
    checkOutput("lu_FlushE", FlushE, 1);
    checkOutput("lu_FlushD", FlushD, 0);
    tick();
    checkOutput("lu_bubble_RegWriteE", RegWriteE, 0);
    checkOutput("lu_bubble_RdE", RdE, 0);
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    checkOutput("lu_RdM", RdM, 5);
    checkOutput("lu_ResultSrcM", ResultSrcM, 1);
    checkOutput("lu_StallD_after", StallD, 0);
    tick();
    checkOutput("lu_Rs1E", Rs1E, 5);
    checkOutput("lu_add_RdE", RdE, 7);
    checkOutput("lu_RdW", RdW, 5);
    checkOutput("lu_RegWriteW", RegWriteW, 1);
    checkOutput("lu_ResultSrcW", ResultSrcW, 1);
    checkOutput("lu_RegWriteM_bubble", RegWriteM, 0);
    checkOutput("lu_ForwardAE", ForwardAE, 2'b01);
    checkOutput("lu_ForwardBE", ForwardBE, 2'b00);
    checkOutput("lu_stall_cnt_hold", stall_cnt, 1);
    doReset();

    // Forward priority: M and W both write x3, M wins
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 3);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 3, 3, 0);
    tick();
    checkOutput("fwd_MW_ForwardAE", ForwardAE, 2'b10);
    checkOutput("fwd_MW_ForwardBE", ForwardBE, 2'b10);
    doReset();

    // Same, but the M instruction does not write: W supplies the operand
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 3);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 3, 3, 0);
    tick();
    checkOutput("fwd_W_ForwardAE", ForwardAE, 2'b01);
    checkOutput("fwd_W_ForwardBE", ForwardBE, 2'b01);
    checkOutput("fwd_W_MemWriteM", MemWriteM, 1);
    doReset();

    // bne in E: taken when Zero=0, not taken when Zero=1
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b001, 3'b010, 1, 2, 0);
    tick();
    ZeroE = 1'b0;
    #1;
    checkOutput("bne_taken_PCSrcE", PCSrcE, 1);
    checkOutput("bne_taken_FlushD", FlushD, 1);
    checkOutput("bne_taken_FlushE", FlushE, 1);
    checkOutput("bne_taken_StallD", StallD, 0);
    ZeroE = 1'b1;
    #1;
    checkOutput("bne_nt_PCSrcE", PCSrcE, 0);
    checkOutput("bne_nt_FlushD", FlushD, 0);
    checkOutput("bne_nt_FlushE", FlushE, 0);
    ZeroE = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 8);
    tick();
    checkOutput("bne_flush_cnt", flush_cnt, 1);
    checkOutput("bne_bubble_RegWriteE", RegWriteE, 0);
    checkOutput("bne_bubble_RdE", RdE, 0);
    checkOutput("bne_bubble_PCSrcE", PCSrcE, 0);

    // blt in E follows LtE
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 3'b000, 1, 2, 0);
    tick();
    LtE = 1'b1;
    #1;
    checkOutput("blt_taken_PCSrcE", PCSrcE, 1);
    LtE = 1'b0;
    #1;
    checkOutput("blt_nt_PCSrcE", PCSrcE, 0);
    doReset();

    // Load-use hazard with a jump in E: the redirect wins
    applyStimulus(1, 0, 1, 0, 0, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 4);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 4, 0, 6);
    checkOutput("sim_StallD", StallD, 0);
    checkOutput("sim_StallF", StallF, 0);
    checkOutput("sim_FlushD", FlushD, 1);
    checkOutput("sim_FlushE", FlushE, 1);
    tick();
    checkOutput("sim_stall_cnt", stall_cnt, 0);
    checkOutput("sim_flush_cnt", flush_cnt, 1);
    checkOutput("sim_bubble_RegWriteE", RegWriteE, 0);
    doReset();

    // x0: a load to x0 neither stalls nor forwards
    applyStimulus(1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1);
    checkOutput("x0_StallD", StallD, 0);
    checkOutput("x0_FlushE", FlushE, 0);
    tick();
    checkOutput("x0_RdE", RdE, 1);
    checkOutput("x0_RegWriteM", RegWriteM, 1);
    checkOutput("x0_ForwardAE", ForwardAE, 2'b00);
    checkOutput("x0_stall_cnt", stall_cnt, 0);
    doReset();

    // Saturation: lw x2,0(x2) held in D stalls on every other edge
    applyStimulus(1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 3'b000, 2, 0, 2);
    repeat (6) tick();
    checkOutput("sat_stall_cnt_3", stall_cnt, 3);
    tick();
    checkOutput("sat_StallD_4th", StallD, 1);
    tick();
    checkOutput("sat_stall_cnt_hold", stall_cnt, 3);
    tick();

    // Reset pulse mid-stall clears everything without a clock edge
    rst_n = 1'b0;
    #1;
    checkOutput("prst_stall_cnt", stall_cnt, 0);
    checkOutput("prst_StallD", StallD, 0);
    checkOutput("prst_FlushE", FlushE, 0);
    checkOutput("prst_RegWriteE", RegWriteE, 0);
    checkOutput("prst_RdE", RdE, 0);
    checkOutput("prst_RdW", RdW, 0);
    checkOutput("prst_RegWriteW", RegWriteW, 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 12, 0, 11);
    tick();
    checkOutput("prst_capture_RdE", RdE, 11);
    checkOutput("prst_capture_RegWriteE", RegWriteE, 1);
    checkOutput("prst_capture_RdM", RdM, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compCount, mismatchCount);
    $finish;
  end

endmodule
